// File: rtl/id_ex_issue_stage.sv
// ID/EX pipeline latch for a dual-issue core: registers the decoded bundle and
// inserts load-use bubbles or splits bundles whose pipe 2 depends on pipe 1.
module id_ex_issue_stage #(
  parameter int REG_W = 3,
  parameter int OP_W  = 4,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [OP_W-1:0]  IF_ID_op_1,
  input  logic [REG_W-1:0] IF_ID_rm_1,
  input  logic [REG_W-1:0] IF_ID_rd_11,
  input  logic [REG_W-1:0] IF_ID_rd_12,
  input  logic [REG_W-1:0] IF_ID_rd_1,
  input  logic [IMM_W-1:0] IF_ID_imm_1,
  input  logic             IF_ID_ALUSrcB,
  input  logic             IF_ID_RegWrite1,
  input  logic             IF_ID_MemRead1,
  input  logic [OP_W-1:0]  IF_ID_op_2,
  input  logic [REG_W-1:0] IF_ID_rm_2,
  input  logic [REG_W-1:0] IF_ID_rn_2,
  input  logic [REG_W-1:0] IF_ID_rd_2,
  input  logic             IF_ID_RegWrite2,
  output logic [OP_W-1:0]  ID_EX_op_1,
  output logic [REG_W-1:0] ID_EX_rm_1,
  output logic [REG_W-1:0] ID_EX_rd_11,
  output logic [REG_W-1:0] ID_EX_rd_12,
  output logic [REG_W-1:0] ID_EX_rd_1,
  output logic [IMM_W-1:0] ID_EX_imm_1,
  output logic             ID_EX_ALUSrcB,
  output logic             ID_EX_RegWrite1,
  output logic             ID_EX_MemRead1,
  output logic [OP_W-1:0]  ID_EX_op_2,
  output logic [REG_W-1:0] ID_EX_rm_2,
  output logic [REG_W-1:0] ID_EX_rn_2,
  output logic [REG_W-1:0] ID_EX_rd_2,
  output logic             ID_EX_RegWrite2,
  output logic             hold_o,
  output logic             split_o
);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rm;
    logic [REG_W-1:0] rd_11;
    logic [REG_W-1:0] rd_12;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             alu_src_b;
    logic             reg_write;
    logic             mem_read;
  } pipe1_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rm;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } pipe2_t;

  typedef enum logic {RUN, SPLIT} state_t;

  pipe1_t p1_in, p1_d, p1_q;
  pipe2_t p2_in, p2_d, p2_q;
  state_t state_d, state_q;

  logic [REG_W-1:0] src_b_1;
  logic lu1, lu2, intra;
  logic issue_1, issue_2, hold;

  assign p1_in = {IF_ID_op_1, IF_ID_rm_1, IF_ID_rd_11, IF_ID_rd_12, IF_ID_rd_1,
                  IF_ID_imm_1, IF_ID_ALUSrcB, IF_ID_RegWrite1, IF_ID_MemRead1};
  assign p2_in = {IF_ID_op_2, IF_ID_rm_2, IF_ID_rn_2, IF_ID_rd_2, IF_ID_RegWrite2};

  // r0 is never a real producer, so it can never cause a stall or a split
  always_comb begin
    src_b_1 = IF_ID_ALUSrcB ? IF_ID_rd_12 : IF_ID_rd_11;
    lu1 = p1_q.mem_read && (p1_q.rd != '0) &&
          ((p1_q.rd == IF_ID_rm_1) || (p1_q.rd == src_b_1));
    lu2 = p1_q.mem_read && (p1_q.rd != '0) &&
          ((p1_q.rd == IF_ID_rm_2) || (p1_q.rd == IF_ID_rn_2) || (p1_q.rd == IF_ID_rd_2));
    intra = IF_ID_RegWrite1 && (IF_ID_rd_1 != '0) &&
            ((IF_ID_rd_1 == IF_ID_rm_2) || (IF_ID_rd_1 == IF_ID_rn_2) ||
             (IF_ID_rd_1 == IF_ID_rd_2));
  end

  always_comb begin
    issue_1 = 1'b0;
    issue_2 = 1'b0;
    hold    = 1'b0;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = RUN;
        end else if (lu1 || lu2) begin
          hold = 1'b1;
        end else if (intra) begin
          issue_1 = 1'b1;
          hold    = 1'b1;
          state_d = SPLIT;
        end else begin
          issue_1 = 1'b1;
          issue_2 = 1'b1;
        end
      end
      SPLIT: begin
        // pipe 1 of this bundle already left; only pipe 2 remains
        if (flush) begin
          state_d = RUN;
        end else if (lu2) begin
          hold = 1'b1;
        end else begin
          issue_2 = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    p1_d = issue_1 ? p1_in : '0;
    p2_d = issue_2 ? p2_in : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_q    <= '0;
      p2_q    <= '0;
      state_q <= RUN;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      state_q <= state_d;
    end
  end

  assign hold_o  = hold && !reset;
  assign split_o = (state_q == SPLIT);

  assign ID_EX_op_1      = p1_q.op;
  assign ID_EX_rm_1      = p1_q.rm;
  assign ID_EX_rd_11     = p1_q.rd_11;
  assign ID_EX_rd_12     = p1_q.rd_12;
  assign ID_EX_rd_1      = p1_q.rd;
  assign ID_EX_imm_1     = p1_q.imm;
  assign ID_EX_ALUSrcB   = p1_q.alu_src_b;
  assign ID_EX_RegWrite1 = p1_q.reg_write;
  assign ID_EX_MemRead1  = p1_q.mem_read;
  assign ID_EX_op_2      = p2_q.op;
  assign ID_EX_rm_2      = p2_q.rm;
  assign ID_EX_rn_2      = p2_q.rn;
  assign ID_EX_rd_2      = p2_q.rd;
  assign ID_EX_RegWrite2 = p2_q.reg_write;

endmodule
